// File: rtl/ram_port_arbiter.sv
// Two-requester (IO, CPU) arbiter for a single-port pixel RAM; one access per three cycles.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration (default: fixed IO priority).
module ram_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_gnt,
  output logic              io_rvalid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              any_req;
  logic              pick_cpu;
  logic              accept;
  logic              we_q;
  logic              winner_cpu_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  assign any_req = io_req | cpu_req;
  assign accept  = (state_q == S_IDLE) && any_req;

`ifdef ARB_ROUND_ROBIN_EN
  // On contention the requester that did not win last time is served.
  logic last_cpu_q;

  assign pick_cpu = cpu_req & (~io_req | ~last_cpu_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_cpu_q <= 1'b1;
    end else if (accept) begin
      last_cpu_q <= pick_cpu;
    end
  end
`else
  assign pick_cpu = cpu_req & ~io_req;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   state_d = any_req ? S_ACCESS : S_IDLE;
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Transaction is captured once in IDLE and held; later req/field changes cannot disturb it.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q         <= 1'b0;
      winner_cpu_q <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else if (accept) begin
      we_q         <= pick_cpu ? cpu_we    : io_we;
      winner_cpu_q <= pick_cpu;
      addr_q       <= pick_cpu ? cpu_addr  : io_addr;
      wdata_q      <= pick_cpu ? cpu_wdata : io_wdata;
    end
  end

  always_comb begin
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    io_gnt     = 1'b0;
    io_rvalid  = 1'b0;
    cpu_gnt    = 1'b0;
    cpu_rvalid = 1'b0;
    unique case (state_q)
      S_ACCESS: begin
        mem_we = we_q;
        mem_re = ~we_q;
      end
      S_RESP: begin
        io_gnt     = ~winner_cpu_q;
        io_rvalid  = ~winner_cpu_q & ~we_q;
        cpu_gnt    = winner_cpu_q;
        cpu_rvalid = winner_cpu_q & ~we_q;
      end
      default: ;
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: timeline-based reference model with per-cycle compare,
// directed literal checks and a constrained-random phase with a RAM model attached.
module tb_ram_port_arbiter;

  logic        clk;
  logic        reset;
  logic        io_req, io_we, cpu_req, cpu_we;
  logic [15:0] io_addr, cpu_addr;
  logic [7:0]  io_wdata, cpu_wdata;
  logic        io_gnt, io_rvalid, cpu_gnt, cpu_rvalid;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we, mem_re;
  logic [7:0]  mem_rdata;

  ram_port_arbiter #(.ADDR_W(16), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_gnt(io_gnt), .io_rvalid(io_rvalid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Synchronous RAM model: data returned one cycle after mem_re.
  logic [7:0] ram    [0:65535];
  logic [7:0] shadow [0:65535];

  always @(posedge clk) begin
    if (mem_we === 1'b1) ram[mem_addr] <= mem_wdata;
    if (mem_re === 1'b1) mem_rdata <= ram[mem_addr];
  end

  // Reference model: one transaction at a time on a cycle timeline.
  // Cycle e is the cycle that starts at posedge number e.
  int         edge_cnt  = 0;
  int         free_from = 0;
  int         rst_cyc   = -1;
  bit         model_ok  = 0;
  bit         rec_valid = 0;
  bit         rec_cpu, rec_we;
  int         strobe_cyc;
  logic [15:0] rec_addr;
  logic [7:0]  rec_wdata, rec_rdata;
  bit         last_cpu  = 1;

  always @(posedge clk) begin
    bit w_cpu;
    edge_cnt++;
    if (reset) begin
      model_ok  = 1;
      rec_valid = 0;
      free_from = edge_cnt;
      rst_cyc   = edge_cnt;
      last_cpu  = 1;
    end else if (model_ok && (edge_cnt - 1 >= free_from) && (io_req || cpu_req)) begin
`ifdef ARB_ROUND_ROBIN_EN
      w_cpu = (io_req && cpu_req) ? !last_cpu : cpu_req;
`else
      w_cpu = !io_req;
`endif
      last_cpu   = w_cpu;
      rec_valid  = 1;
      rec_cpu    = w_cpu;
      rec_we     = w_cpu ? cpu_we : io_we;
      rec_addr   = w_cpu ? cpu_addr : io_addr;
      rec_wdata  = w_cpu ? cpu_wdata : io_wdata;
      strobe_cyc = edge_cnt;
      free_from  = edge_cnt + 2;
      if (rec_we) shadow[rec_addr] = rec_wdata;
      else        rec_rdata = shadow[rec_addr];
    end
  end

  // Per-cycle compare against the model, sampled mid-cycle.
  always @(negedge clk) begin
    bit strobe_now, gnt_now;
    logic [5:0] exp_flags, act_flags;
    if (model_ok) begin
      strobe_now = rec_valid && (edge_cnt == strobe_cyc);
      gnt_now    = rec_valid && (edge_cnt == strobe_cyc + 1);
      exp_flags  = {strobe_now && rec_we, strobe_now && !rec_we,
                    gnt_now && !rec_cpu, gnt_now && !rec_cpu && !rec_we,
                    gnt_now && rec_cpu, gnt_now && rec_cpu && !rec_we};
      act_flags  = {mem_we, mem_re, io_gnt, io_rvalid, cpu_gnt, cpu_rvalid};
      check($sformatf("c%0d flags{we,re,iog,iorv,cpug,cpurv}", edge_cnt), 32'(act_flags), 32'(exp_flags));
      if (strobe_now) begin
        check($sformatf("c%0d mem_addr", edge_cnt), 32'(mem_addr), 32'(rec_addr));
        check($sformatf("c%0d mem_wdata", edge_cnt), 32'(mem_wdata), 32'(rec_wdata));
      end
      if (edge_cnt == rst_cyc) begin
        check($sformatf("c%0d reset addr/wdata", edge_cnt), {8'h0, mem_addr, mem_wdata}, 32'h0);
      end
      if (gnt_now && !rec_we) begin
        check($sformatf("c%0d mem_rdata", edge_cnt), 32'(mem_rdata), 32'(rec_rdata));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    io_req = 0; io_we = 0; io_addr = '0; io_wdata = '0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  function automatic logic [15:0] rnd_addr();
    case ($urandom_range(0, 3))
      0:       return 16'hFFFF;
      1:       return {12'hFFF, 4'($urandom_range(0, 15))};
      default: return {12'h000, 4'($urandom_range(0, 15))};
    endcase
  endfunction

  int order [4];
  int exp_order [4];
  int got;
  int budget;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram[i]    = 8'(i) ^ 8'h5A;
      shadow[i] = 8'(i) ^ 8'h5A;
    end
    ram[16'hFFFF]    = 8'h3C;
    shadow[16'hFFFF] = 8'h3C;
    idle_inputs();
    reset = 1;

    reset_dut();
    check("reset outputs", {mem_we, mem_re, io_gnt, io_rvalid, cpu_gnt, cpu_rvalid, mem_addr, mem_wdata}, 32'h0);

    // Single IO write
    io_req = 1; io_we = 1; io_addr = 16'h0010; io_wdata = 8'hA5;
    tick();
    check("wr N+1 mem_we/re", {mem_we, mem_re}, 32'h2);
    check("wr N+1 mem_addr", 32'(mem_addr), 32'h0010);
    check("wr N+1 mem_wdata", 32'(mem_wdata), 32'hA5);
    tick();
    check("wr N+2 io_gnt/rvalid", {io_gnt, io_rvalid, cpu_gnt}, 32'h4);
    io_req = 0;
    tick();
    check("wr N+3 idle", {mem_we, mem_re, io_gnt, cpu_gnt}, 32'h0);

    // CPU read of the last address
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'hFFFF; cpu_wdata = 8'h00;
    tick();
    check("rd N+1 mem_re", {mem_we, mem_re}, 32'h1);
    check("rd N+1 mem_addr", 32'(mem_addr), 32'hFFFF);
    tick();
    check("rd N+2 cpu_gnt/rvalid", {cpu_gnt, cpu_rvalid, io_gnt}, 32'h6);
    check("rd N+2 mem_rdata", 32'(mem_rdata), 32'h3C);
    cpu_req = 0;
    tick();

    // Sustained contention
    reset_dut();
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    order = '{2, 2, 2, 2};
    io_req = 1; io_we = 0; io_addr = 16'h0003;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'hFFF7;
    got = 0;
    budget = 0;
    while (got < 4 && budget < 40) begin
      tick();
      budget++;
      if (io_gnt || cpu_gnt) begin
        order[got] = cpu_gnt ? 1 : 0;
        got++;
      end
    end
    check("contention gnt count", 32'(got), 32'd4);
    check("contention gnt cycles", 32'(budget), 32'd11);
    for (int i = 0; i < 4; i++) check($sformatf("contention order[%0d] (1=CPU)", i), 32'(order[i]), 32'(exp_order[i]));
    idle_inputs();
    tick();
    tick();

    // Reset during ACCESS aborts the transaction
    io_req = 1; io_we = 1; io_addr = 16'h0020; io_wdata = 8'h11;
    tick();
    check("abort N+1 mem_we", 32'(mem_we), 32'h1);
    reset = 1;
    io_req = 0;
    tick();
    check("abort N+2 all zero", {mem_we, mem_re, io_gnt, io_rvalid, cpu_gnt, cpu_rvalid, mem_addr, mem_wdata}, 32'h0);
    reset = 0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h1234; cpu_wdata = 8'h77;
    tick();
    check("post-reset N+1 mem_we", {mem_we, mem_re}, 32'h2);
    check("post-reset N+1 addr/data", {8'h0, mem_addr, mem_wdata}, 32'h00123477);
    cpu_req = 0;
    tick();
    check("post-reset N+2 cpu_gnt", {cpu_gnt, cpu_rvalid, io_gnt}, 32'h4);
    tick();

    // io_req dropped during ACCESS
    io_req = 1; io_we = 1; io_addr = 16'h0005; io_wdata = 8'hC3;
    tick();
    check("drop N+1 mem_we", 32'(mem_we), 32'h1);
    io_req = 0;
    io_addr = 16'h0BAD;
    tick();
    check("drop N+2 io_gnt", {io_gnt, io_rvalid}, 32'h2);
    tick();

    // Random traffic with occasional resets
    for (int n = 0; n < 10000; n++) begin
      reset     = ($urandom_range(0, 399) == 0);
      io_req    = ($urandom_range(0, 3) != 0);
      io_we     = 1'($urandom_range(0, 1));
      io_addr   = rnd_addr();
      io_wdata  = 8'($urandom_range(0, 255));
      cpu_req   = ($urandom_range(0, 3) != 0);
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_addr  = rnd_addr();
      cpu_wdata = 8'($urandom_range(0, 255));
      tick();
    end
    reset = 0;
    idle_inputs();
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
